exec_unit: RTL
==============

// Module: exec_unit
// PURPOSE
//  Execute stage directly downstream of the 4-entry register file. Consumes read operands v1/v2.
//  Computes a single-cycle ALU op, a half-word load, or an iterative N-cycle multiply.
//  Drives the register file's write port (w1/mask/w) as a registered, one-cycle write.
//  mask==0 means "no write"; the register file needs no separate write enable.
// PARAMETERS
//  N          32  datapath width; v1, v2, w and mask width
//  RA_W       2   register address width (4 registers)
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst_n      in   1      synchronous active-low reset; sampled on rising clk
//  in_valid   in   1      op/rd/v1/v2 hold a valid instruction
//  in_ready   out  1      unit can accept; in_valid&&in_ready = accept
//  op         in   4      operation code, exec_pkg::op_t
//  rd         in   RA_W   destination register
//  v1         in   N      operand A (register-file read port 1)
//  v2         in   N      operand B (register-file read port 2)
//  w1         out  RA_W   write address to register file
//  mask       out  N      per-bit write mask to register file; 0 = no write
//  w          out  N      write data to register file
//  busy       out  1      multiply in progress
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge): state=IDLE, in_ready=1, busy=0, w1=0, mask=0, w=0.
//   Multiplier counter and accumulator are cleared.
//  Reset mid-multiply aborts it with no write issued. A reset cycle never produces a write.
//  Ops: ADD=0 v1+v2 (mod 2^N); SUB=1 v1-v2 (mod 2^N); AND=2; OR=3; XOR=4;
//   SLL=5 v1<<v2[4:0]; SRL=6 logical v1>>v2[4:0];
//   LDL=7 w=v2, mask=32'h0000FFFF; LDH=8 w=v2<<16, mask=32'hFFFF0000; MUL=9 low N bits of v1*v2.
//  Op codes 10-15 are NOP: accepted, no write (mask=0).
//  All non-MUL ops use mask=all ones.
//  Single-cycle ops: accepted at edge T -> w1/mask/w valid for exactly the cycle after T, then mask=0.
//   Back-to-back accepts give back-to-back writes.
//  States: IDLE, MUL.
//   IDLE: in_ready=1. On accepting MUL: latch v1, v2, rd; acc=0; cnt=0; go to MUL. mask=0 that cycle.
//   MUL: in_ready=0, busy=1. Shift-add one bit per cycle: if b[cnt] then acc+=a<<cnt.
//    After N iterations (cnt==N-1): present acc on w, mask=all ones, w1=rd; return to IDLE.
//    Latency: accept at T -> write visible in cycle T+N+1.
//  in_valid while in_ready=0 is ignored. Upstream holds the instruction until accepted.
//  The write of the final MUL cycle and a new accept in the following IDLE cycle do not collide:
//   the write register is loaded once per cycle by whichever source completed.
//  rd is latched at accept. Later changes on the input bus do not affect the pending write.
//  Overflow and carry are discarded; no flags are produced.
// STRUCTURE
//  exec_pkg: op_t enum (ADD..MUL, NOP), state_t {IDLE, MUL}, MASK_ALL/MASK_LO/MASK_HI constants.
//  Sub-module seq_multiplier: start, a, b -> done, p. Shift-add, N cycles, sync active-low reset.
//  exec_unit holds the ALU case, the FSM and the output write register.
// TESTING
//  Reset: rst_n=0 for 2 clk -> mask=0, w=0, w1=0, in_ready=1, busy=0.
//  ADD rd=1, v1=32'hFFFFFFFF, v2=2 -> next cycle w1=1, w=32'h00000001, mask=32'hFFFFFFFF;
//   the cycle after, mask=0.
//  LDH rd=2, v2=32'h0000CAFE then LDL rd=2, v2=32'h0000BABE, back-to-back ->
//   mask=FFFF0000, w=CAFE0000; then mask=0000FFFF, w=0000BABE. Register 2 reads CAFEBABE.
//  MUL rd=3, v1=32'h00010001, v2=32'h00000003 -> in_ready low for N cycles;
//   write w=32'h00030003 at T+33; in_valid during busy is ignored.
//  MUL 32'hFFFFFFFF*32'hFFFFFFFF -> w=32'h00000001 (wrap-around).
//   Assert rst_n=0 at iteration 10 of a second MUL -> no write, IDLE next cycle.
//  End-to-end with the register file: ADD r0=r1+r2 after LDL loads r1=5, r2=7 -> register 0 reads 12.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: opcodes, FSM states and write masks.
package exec_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] MASK_ALL = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] MASK_LO  = 32'h0000_FFFF;
  localparam logic [XLEN-1:0] MASK_HI  = 32'hFFFF_0000;

  // Codes 11-15 are not named here and decode as NOP, like OP_NOP itself.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_LDL = 4'd7,
    OP_LDH = 4'd8,
    OP_MUL = 4'd9,
    OP_NOP = 4'd10
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exec_unit_seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, N cycles, low N bits of a*b.
// done is asserted during the last iteration, with the final product already on p.
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] p
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [N-1:0]  w_acc_next;

  assign w_acc_next = r_b[r_cnt] ? r_acc + (r_a << r_cnt) : r_acc;
  assign done       = r_run && (r_cnt == CW'(N - 1));
  assign p          = w_acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/half-word loads, iterative multiply, and the
// registered one-cycle write port (w1/mask/w) into the register file.
module exec_unit
  import exec_pkg::*;
#(
  parameter int N    = XLEN,
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [RA_W-1:0] rd,
  input  logic [N-1:0]    v1,
  input  logic [N-1:0]    v2,
  output logic [RA_W-1:0] w1,
  output logic [N-1:0]    mask,
  output logic [N-1:0]    w,
  output logic            busy
);

  localparam int SH_W = $clog2(N);

  state_t          r_state;
  logic [RA_W-1:0] r_rd;
  op_t             w_op;
  logic            w_accept;
  logic            w_mul_start;
  logic            w_mul_done;
  logic [N-1:0]    w_mul_p;
  logic [N-1:0]    w_alu_w;
  logic [N-1:0]    w_alu_mask;

  assign w_op        = op_t'(op);
  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_MUL);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_op == OP_MUL);

  seq_multiplier #(.N(N)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mul_start),
    .a     (v1),
    .b     (v2),
    .done  (w_mul_done),
    .p     (w_mul_p)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_alu_w    = '0;
    w_alu_mask = N'(MASK_ALL);
    case (w_op)
      OP_ADD:  w_alu_w = v1 + v2;
      OP_SUB:  w_alu_w = v1 - v2;
      OP_AND:  w_alu_w = v1 & v2;
      OP_OR:   w_alu_w = v1 | v2;
      OP_XOR:  w_alu_w = v1 ^ v2;
      OP_SLL:  w_alu_w = v1 << v2[SH_W-1:0];
      OP_SRL:  w_alu_w = v1 >> v2[SH_W-1:0];
      OP_LDL: begin
        w_alu_w    = v2;
        w_alu_mask = N'(MASK_LO);
      end
      OP_LDH: begin
        w_alu_w    = v2 << 16;
        w_alu_mask = N'(MASK_HI);
      end
      default: w_alu_mask = '0;  // MUL writes later from the multiplier; NOPs never write
    endcase
  end

  // Only one source can complete per cycle: accepts happen in IDLE, multiply
  // completion in MUL, so the write register never has two contenders.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rd    <= '0;
      w1      <= '0;
      mask    <= '0;
      w       <= '0;
    end else begin
      w1   <= '0;
      mask <= '0;
      w    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state <= ST_MUL;
              r_rd    <= rd;
            end else if (w_alu_mask != '0) begin
              w1   <= rd;
              mask <= w_alu_mask;
              w    <= w_alu_w;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state <= ST_IDLE;
            w1      <= r_rd;
            mask    <= N'(MASK_ALL);
            w       <= w_mul_p;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
